// File: rtl/cic_uart_tx_if.sv
// Sample bus from the CIC decimators: a one-cycle strobe qualifying three channel words.
interface cic_uart_tx_if #(
  parameter int W = 24
) ();
  logic         sample_stb;
  logic [W-1:0] ch0;
  logic [W-1:0] ch1;
  logic [W-1:0] ch2;

  modport master (output sample_stb, ch0, ch1, ch2);
  modport slave  (input  sample_stb, ch0, ch1, ch2);
endinterface

// File: rtl/cic_uart_tx.sv
// Snapshots three CIC channel words on a sample strobe and sends them as one
// SYNC-prefixed 8N1 UART frame, MSB byte of each channel first.
module cic_uart_tx #(
  parameter int          W            = 24,
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC         = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  cic_uart_tx_if.slave      s_if,
  output logic              tx,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        frame_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: sample_stb is a one-cycle valid with no ready. It is accepted
  // only when busy=0 at the sampling edge; otherwise it is dropped and flagged
  // in the sticky overrun bit.

  localparam int NBYTES = 1 + 3 * W / 8;
  localparam int BYW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BCW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [BCW-1:0]   baud_cnt;
  logic [2:0]       bit_cnt;
  logic [BYW-1:0]   bytes_left;
  logic [7:0]       cur_byte;
  logic [3*W-1:0]   shadow;
  logic             tx_n;
  logic             baud_end;
  logic             accept;
  logic             shift_bit;
  logic             load_byte;
  logic             done;

  assign baud_end  = (baud_cnt == BCW'(CLKS_PER_BIT - 1));
  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    accept    = 1'b0;
    shift_bit = 1'b0;
    load_byte = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (s_if.sample_stb && !busy) begin
          accept  = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          tx_n    = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_bit = 1'b1;
            tx_n      = cur_byte[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (bytes_left == '0) begin
            done    = 1'b1;
            state_n = IDLE;
            tx_n    = 1'b1;
          end else begin
            // Back-to-back bytes: start bit begins right after the stop bit.
            load_byte = 1'b1;
            state_n   = START;
            tx_n      = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= 8'd0;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      bytes_left <= '0;
      cur_byte   <= 8'd0;
      shadow     <= '0;
    end else begin
      state <= state_n;
      tx    <= tx_n;

      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + BCW'(1);

      if (state == START && baud_end) bit_cnt <= 3'd0;
      else if (shift_bit)             bit_cnt <= bit_cnt + 3'd1;

      // The shadow shifts up a byte per load so the next byte is always on top.
      if (accept) begin
        shadow     <= {s_if.ch0, s_if.ch1, s_if.ch2};
        cur_byte   <= SYNC;
        bytes_left <= BYW'(NBYTES - 1);
        busy       <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end else if (load_byte) begin
        cur_byte   <= shadow[3*W-1 -: 8];
        shadow     <= {shadow[3*W-9:0], 8'h00};
        bytes_left <= bytes_left - BYW'(1);
      end else if (shift_bit) begin
        cur_byte <= {1'b0, cur_byte[7:1]};
      end

      if (done) busy <= 1'b0;

      if (s_if.sample_stb && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_uart_tx.sv
// Bench for cic_uart_tx: table vectors, random frames against a byte-level
// UART model, and hand-written reset/overrun/wrap sequences.
module tb_cic_uart_tx;

  localparam int W     = 24;
  localparam int CPB   = 4;
  localparam int NB    = 1 + 3 * W / 8;
  localparam int FRAME = NB * 10 * CPB;
  localparam int WW    = 8;
  localparam int WCPB  = 2;
  localparam int WFRM  = (1 + 3 * WW / 8) * 10 * WCPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx, busy, overrun;
  logic [7:0] frame_cnt;
  logic [1:0] state_dbg;
  logic       rst_w;
  logic       tx_w, busy_w, ov_w;
  logic [7:0] fc_w;
  logic [1:0] st_w;

  int errors = 0;
  int checks = 0;
  int fc_model = 0;
  bit ov_model = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [23:0] c0, c1, c2;
    logic [79:0] bytes;
  } vec_t;
  vec_t tbl[3];

  cic_uart_tx_if #(.W(W))  mif ();
  cic_uart_tx_if #(.W(WW)) wif ();

  cic_uart_tx #(.W(W), .CLKS_PER_BIT(CPB), .SYNC(8'hA5)) u_dut (
    .clk(clk), .reset(rst), .s_if(mif.slave), .tx(tx), .busy(busy),
    .overrun(overrun), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  cic_uart_tx #(.W(WW), .CLKS_PER_BIT(WCPB), .SYNC(8'hA5)) u_wrap (
    .clk(clk), .reset(rst_w), .s_if(wif.slave), .tx(tx_w), .busy(busy_w),
    .overrun(ov_w), .frame_cnt(fc_w), .state_dbg(st_w)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame = SYNC then each channel MSB byte first.
  task automatic push_model(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    logic [23:0] chs[3];
    chs[0] = c0; chs[1] = c1; chs[2] = c2;
    exp_q.push_back(8'hA5);
    for (int c = 0; c < 3; c++)
      for (int k = 2; k >= 0; k--)
        exp_q.push_back(8'((chs[c] >> (8 * k)) & 24'hFF));
  endtask

  task automatic push_table(input logic [79:0] b);
    for (int k = NB - 1; k >= 0; k--)
      exp_q.push_back(8'((b >> (8 * k)) & 80'hFF));
  endtask

  // Driver + per-cycle monitor for one strobed frame on the main DUT.
  task automatic run_frame(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                           input bit scramble, input int ov_at, input int rst_at);
    logic [7:0] fb[NB];
    logic       wave[FRAME];
    logic       cap[FRAME];
    int         tx_bad, busy_bad, ov_bad, base;
    logic [7:0] dec;
    for (int b = 0; b < NB; b++) fb[b] = exp_q.pop_front();
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < 10; j++)
        for (int c = 0; c < CPB; c++)
          wave[(b * 10 + j) * CPB + c] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : fb[b][j - 1];
    tx_bad = 0; busy_bad = 0; ov_bad = 0;
    mif.ch0 = c0; mif.ch1 = c1; mif.ch2 = c2;
    mif.sample_stb = 1'b1;
    tick();
    mif.sample_stb = 1'b0;
    fc_model++;
    for (int i = 0; i < FRAME; i++) begin
      cap[i] = tx;
      if (tx !== wave[i]) tx_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (overrun !== ov_model) ov_bad++;
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fc_model = 0;
        ov_model = 1'b0;
        chk("rst_tx_wave", tx_bad, 0);
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_frame_cnt", frame_cnt, 8'd0);
        chk("rst_mid_overrun", overrun, 1'b0);
        return;
      end
      if (scramble) begin
        mif.ch0 = 24'($urandom); mif.ch1 = 24'($urandom); mif.ch2 = 24'($urandom);
      end
      mif.sample_stb = (i == ov_at);
      tick();
      if (i == ov_at) ov_model = 1'b1;
    end
    mif.sample_stb = 1'b0;
    chk("tx_wave_bad_cycles", tx_bad, 0);
    chk("busy_len_bad_cycles", busy_bad, 0);
    chk("overrun_bad_cycles", ov_bad, 0);
    chk("end_busy", busy, 1'b0);
    chk("end_tx", tx, 1'b1);
    chk("end_overrun", overrun, ov_model);
    chk("end_frame_cnt", frame_cnt, 32'(fc_model & 8'hFF));
    // Independent receiver: sample each bit mid-cell from the captured line.
    for (int b = 0; b < NB; b++) begin
      base = b * 10 * CPB + CPB / 2;
      for (int j = 0; j < 8; j++) dec[j] = cap[base + (j + 1) * CPB];
      chk("rx_framing", {cap[base], cap[base + 9 * CPB]}, 2'b01);
      chk("rx_byte", dec, fb[b]);
    end
  endtask

  initial begin
    int bad_tx, bad_busy, bad_ov, bad_fc, n, wrap_bad;
    logic [23:0] r0, r1, r2;

    tbl[0] = '{24'h123456, 24'hABCDEF, 24'h000001, 80'hA5123456ABCDEF000001};
    tbl[1] = '{24'hFFFFFF, 24'h000000, 24'h800000, 80'hA5FFFFFF000000800000};
    tbl[2] = '{24'h00FF00, 24'h5A5A5A, 24'hC3A500, 80'hA500FF005A5A5AC3A500};

    rst = 1'b1; rst_w = 1'b1;
    mif.sample_stb = 1'b0; mif.ch0 = '0; mif.ch1 = '0; mif.ch2 = '0;
    wif.sample_stb = 1'b0; wif.ch0 = '0; wif.ch1 = '0; wif.ch2 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_cnt", frame_cnt, 8'd0);

    bad_tx = 0; bad_busy = 0; bad_ov = 0; bad_fc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (overrun !== 1'b0) bad_ov++;
      if (frame_cnt !== 8'd0) bad_fc++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_overrun", bad_ov, 0);
    chk("idle_frame_cnt", bad_fc, 0);

    // Strobe coincident with reset is not captured.
    rst = 1'b1; mif.sample_stb = 1'b1;
    tick();
    rst = 1'b0; mif.sample_stb = 1'b0;
    chk("rst_stb_frame_cnt", frame_cnt, 8'd0);
    chk("rst_stb_tx", tx, 1'b1);
    tick();
    chk("rst_stb_busy", busy, 1'b0);

    for (int t = 0; t < 3; t++) begin
      push_table(tbl[t].bytes);
      run_frame(tbl[t].c0, tbl[t].c1, tbl[t].c2, 1'b0, -1, -1);
    end

    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b1, -1, -1);

    // Overrun 50 cycles in, then a strobe one cycle after busy falls.
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b0, 50, -1);
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b0, -1, -1);

    // Reset at cycle 150, then a clean frame.
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b0, -1, 150);
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b0, -1, -1);

    // Strobe on the edge where busy falls counts as overrun and is dropped.
    r0 = 24'($urandom); r1 = 24'($urandom); r2 = 24'($urandom);
    push_model(r0, r1, r2);
    run_frame(r0, r1, r2, 1'b0, FRAME - 1, -1);
    tick();
    chk("edge_stb_dropped_busy", busy, 1'b0);
    chk("edge_stb_dropped_tx", tx, 1'b1);

    for (int f = 0; f < 3; f++) begin
      r0 = 24'($urandom_range(0, 24'hFFFFFF));
      r1 = 24'($urandom); r2 = 24'($urandom);
      push_model(r0, r1, r2);
      run_frame(r0, r1, r2, 1'b0, -1, -1);
    end

    // Wrap: 256 back-to-back frames on a narrow fast instance.
    rst_w = 1'b1; tick(); rst_w = 1'b0; tick();
    wrap_bad = 0;
    for (int f = 0; f < 256; f++) begin
      wif.ch0 = 8'($urandom); wif.ch1 = 8'($urandom); wif.ch2 = 8'($urandom);
      wif.sample_stb = 1'b1;
      tick();
      wif.sample_stb = 1'b0;
      n = 0;
      while (busy_w === 1'b1 && n < 200) begin
        tick();
        n++;
      end
      if (n != WFRM) wrap_bad++;
      if (f == 254) chk("wrap_frame_cnt_255", fc_w, 8'd255);
    end
    chk("wrap_len_bad_frames", wrap_bad, 0);
    chk("wrap_frame_cnt_0", fc_w, 8'd0);
    chk("wrap_overrun", ov_w, 1'b0);
    chk("wrap_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
